// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-number width and the hazard scoreboard slot record.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rnum;
        logic             isLoad;
    } slot_t;

    // True when a valid in-flight destination feeds an operand the ID instruction really reads.
    function automatic logic slot_match(input slot_t s,
                                        input logic use_rs, input logic [REG_W-1:0] rs,
                                        input logic use_rt, input logic [REG_W-1:0] rt);
        return s.valid && ((use_rs && (rs == s.rnum)) || (use_rt && (rt == s.rnum)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow EX/MEM scoreboard, load-use and branch-in-ID stall
// detection, taken-branch IF/ID squash, and stall/flush event counters.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validID,
    input  logic [REG_W-1:0] rsID,
    input  logic [REG_W-1:0] rtID,
    input  logic             useRsID,
    input  logic             useRtID,
    input  logic [REG_W-1:0] wrRegID,
    input  logic             regWriteID,
    input  logic             memReadID,
    input  logic             branchID,
    input  logic             takenID,
    output logic             pcWrite,
    output logic             stallIFID,
    output logic             flushIFID,
    output logic             flushIDEX,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    slot_t ex_slot_q;
    slot_t ex_slot_d;
    slot_t mem_slot_q;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_haz;
    logic stall;
    logic flush;

    always_comb begin
        ex_match  = slot_match(ex_slot_q,  useRsID, rsID, useRtID, rtID);
        mem_match = slot_match(mem_slot_q, useRsID, rsID, useRtID, rtID);
        load_use  = validID && ex_slot_q.isLoad && ex_match;
        // A branch compares in ID, so it also waits on ALU results still in EX and loads in MEM.
        br_haz    = validID && branchID && (ex_match || (mem_slot_q.isLoad && mem_match));
        stall     = load_use || br_haz;
        flush     = validID && takenID && !stall;
    end

    // A stalled instruction becomes an ID/EX bubble, so it must not enter the scoreboard.
    always_comb begin
        ex_slot_d = '0;
        if (validID && regWriteID && (wrRegID != REG_ZERO) && !stall) begin
            ex_slot_d.valid  = 1'b1;
            ex_slot_d.rnum   = wrRegID;
            ex_slot_d.isLoad = memReadID;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_slot_q  <= '0;
            mem_slot_q <= '0;
        end else begin
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= ex_slot_q;
        end
    end

    assign pcWrite   = !stall;
    assign stallIFID = stall;
    assign flushIDEX = stall;
    assign flushIFID = flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flushCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle vector table plus reset-mid-stall and saturation sequences.
module tb_hazard_unit;

    localparam logic [3:0] RUN = 4'b1000;  // {pcWrite, stallIFID, flushIFID, flushIDEX}
    localparam logic [3:0] STL = 4'b0101;
    localparam logic [3:0] FLS = 4'b1010;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] wr;
        logic       rw;
        logic       mr;
        logic       br;
        logic       tk;
        logic [3:0] exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       validID, useRsID, useRtID, regWriteID, memReadID, branchID, takenID;
    logic [4:0] rsID, rtID, wrRegID;
    logic       pcWrite, stallIFID, flushIFID, flushIDEX;
    logic [15:0] stallCnt, flushCnt;
    logic       s_pcWrite, s_stallIFID, s_flushIFID, s_flushIDEX;
    logic [3:0] s_stallCnt, s_flushCnt;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .validID(validID), .rsID(rsID), .rtID(rtID),
        .useRsID(useRsID), .useRtID(useRtID), .wrRegID(wrRegID), .regWriteID(regWriteID),
        .memReadID(memReadID), .branchID(branchID), .takenID(takenID),
        .pcWrite(pcWrite), .stallIFID(stallIFID), .flushIFID(flushIFID), .flushIDEX(flushIDEX),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    hazard_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .validID(validID), .rsID(rsID), .rtID(rtID),
        .useRsID(useRsID), .useRtID(useRtID), .wrRegID(wrRegID), .regWriteID(regWriteID),
        .memReadID(memReadID), .branchID(branchID), .takenID(takenID),
        .pcWrite(s_pcWrite), .stallIFID(s_stallIFID), .flushIFID(s_flushIFID), .flushIDEX(s_flushIDEX),
        .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
    );

    function automatic vec_t mk(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] wr, input logic rw,
                                input logic mr, input logic br, input logic tk, input logic [3:0] e,
                                input string n);
        vec_t x;
        x.rst = rst; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.wr = wr;
        x.rw = rw; x.mr = mr; x.br = br; x.tk = tk; x.exp = e; x.name = n;
        return x;
    endfunction

    // lw $dst, 0($base)
    function automatic vec_t lw(input logic rst, input logic [4:0] dst, input logic [4:0] base,
                                input logic [3:0] e, input string n);
        return mk(rst, 1'b1, base, dst, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0, e, n);
    endfunction

    // add $rd, $rs, $rt
    function automatic vec_t alu(input logic rst, input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [3:0] e, input string n);
        return mk(rst, 1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0, e, n);
    endfunction

    // beq/bne $rs, $rt
    function automatic vec_t brn(input logic [4:0] rs, input logic [4:0] rt, input logic tk,
                                 input logic [3:0] e, input string n);
        return mk(1'b0, 1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, tk, e, n);
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        validID = x.v; rsID = x.rs; rtID = x.rt; useRsID = x.urs; useRtID = x.urt;
        wrRegID = x.wr; regWriteID = x.rw; memReadID = x.mr; branchID = x.br; takenID = x.tk;
    endtask

    task automatic bubble();
        drive(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, "bubble"));
    endtask

    task automatic do_reset();
        bubble();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        #1;
        chk("reset_outs", 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(RUN));
        chk("reset_stallCnt", 32'(stallCnt), 32'd0);
        chk("reset_flushCnt", 32'(flushCnt), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bubble();
        exp_stall = '0;
        exp_flush = '0;

        // load-use
        vecs.push_back(lw (1'b1, 5'd2, 5'd1,          RUN, "lu_lw2"));
        vecs.push_back(alu(1'b0, 5'd3, 5'd2, 5'd4,    STL, "lu_add_stall"));
        vecs.push_back(alu(1'b0, 5'd3, 5'd2, 5'd4,    RUN, "lu_add_go"));
        // branch immediately after load: two stalls then squash
        vecs.push_back(lw (1'b1, 5'd2, 5'd1,          RUN, "bl_lw2"));
        vecs.push_back(brn(5'd2, 5'd0, 1'b1,          STL, "bl_beq_s1"));
        vecs.push_back(brn(5'd2, 5'd0, 1'b1,          STL, "bl_beq_s2"));
        vecs.push_back(brn(5'd2, 5'd0, 1'b1,          FLS, "bl_beq_flush"));
        // branch after ALU producer
        vecs.push_back(alu(1'b1, 5'd5, 5'd1, 5'd1,    RUN, "ba_add5"));
        vecs.push_back(brn(5'd5, 5'd6, 1'b0,          STL, "ba_bne_stall"));
        vecs.push_back(brn(5'd5, 5'd6, 1'b0,          RUN, "ba_bne_go"));
        // same with an independent instruction between
        vecs.push_back(alu(1'b1, 5'd5, 5'd1, 5'd1,    RUN, "bi_add5"));
        vecs.push_back(alu(1'b0, 5'd9, 5'd1, 5'd1,    RUN, "bi_add9"));
        vecs.push_back(brn(5'd5, 5'd6, 1'b1,          FLS, "bi_bne_flush"));
        // branch two after a load: one stall
        vecs.push_back(lw (1'b1, 5'd2, 5'd1,          RUN, "b2_lw2"));
        vecs.push_back(alu(1'b0, 5'd9, 5'd1, 5'd1,    RUN, "b2_add9"));
        vecs.push_back(brn(5'd2, 5'd0, 1'b1,          STL, "b2_beq_stall"));
        vecs.push_back(brn(5'd2, 5'd0, 1'b1,          FLS, "b2_beq_flush"));
        // $0 destination and unused operand
        vecs.push_back(lw (1'b1, 5'd0, 5'd1,          RUN, "z_lw0"));
        vecs.push_back(alu(1'b0, 5'd3, 5'd0, 5'd0,    RUN, "z_use0"));
        vecs.push_back(lw (1'b0, 5'd7, 5'd1,          RUN, "u_lw7"));
        vecs.push_back(mk(1'b0, 1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, RUN, "u_rt7_unused"));
        // invalid ID slot asserts nothing even with hazard-shaped inputs
        vecs.push_back(lw (1'b1, 5'd2, 5'd1,          RUN, "v_lw2"));
        vecs.push_back(mk(1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, RUN, "v_bubble"));
        vecs.push_back(alu(1'b0, 5'd3, 5'd2, 5'd4,    RUN, "v_add_after_bubble"));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i]);
            #2;
            chk({vecs[i].name, "_outs"}, 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(vecs[i].exp));
            chk({vecs[i].name, "_stallCnt"}, 32'(stallCnt), 32'(exp_stall));
            chk({vecs[i].name, "_flushCnt"}, 32'(flushCnt), 32'(exp_flush));
            step();
            if (vecs[i].exp[2]) exp_stall = exp_stall + 16'd1;
            if (vecs[i].exp[1]) exp_flush = exp_flush + 16'd1;
        end

        // reset asserted during the second stall of branch-after-load
        do_reset();
        drive(lw(1'b0, 5'd2, 5'd1, RUN, "rm_lw2"));
        step();
        drive(brn(5'd2, 5'd0, 1'b1, STL, "rm_beq"));
        #2;
        chk("rm_stall1", 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(STL));
        step();
        #1;
        chk("rm_stall2", 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(STL));
        chk("rm_stall2_cnt", 32'(stallCnt), 32'd1);
        reset = 1'b1;
        #1;
        chk("rm_rst_outs", 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(FLS));
        chk("rm_rst_stallCnt", 32'(stallCnt), 32'd0);
        chk("rm_rst_flushCnt", 32'(flushCnt), 32'd0);
        step();
        reset = 1'b0;
        drive(alu(1'b0, 5'd3, 5'd2, 5'd4, RUN, "rm_add"));
        #2;
        chk("rm_fresh_add", 32'({pcWrite, stallIFID, flushIFID, flushIDEX}), 32'(RUN));
        step();

        // saturation of the 4-bit instance
        do_reset();
        for (int p = 0; p < 20; p++) begin
            drive(lw(1'b0, 5'd2, 5'd1, RUN, "sat_lw"));
            step();
            drive(alu(1'b0, 5'd3, 5'd2, 5'd4, STL, "sat_add"));
            step();
            step();
        end
        bubble();
        #1;
        chk("sat_stallCnt_4b", 32'(s_stallCnt), 32'hF);
        chk("sat_flushCnt_4b", 32'(s_flushCnt), 32'h0);
        chk("sat_stallCnt_16b", 32'(stallCnt), 32'd20);
        step();
        chk("sat_hold_4b", 32'(s_stallCnt), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It drives the `stall`/`flush` inputs of the IF/ID and ID/EX pipeline registers and the PC write enable. It keeps its own two-entry shadow scoreboard of in-flight destination registers in EX and MEM, so it can detect load-use hazards and branch-in-ID operand hazards without reading the pipeline registers back. It also counts stall and flush events for performance debug.

## Interface
- `CNT_W`, 16: width of each saturating event counter.

- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `validID`  in  1: IF/ID holds a real instruction (0 means a bubble).
- `rsID`, `rtID`  in  5 each: source register numbers in ID.
- `useRsID`, `useRtID`  in  1 each: the instruction actually reads rs / rt.
- `wrRegID`  in  5: destination register after the RegDst mux.
- `regWriteID`, `memReadID`  in  1 each: ID control bits.
- `branchID`  in  1: the ID instruction is a branch comparing in ID.
- `takenID`  in  1: branch taken or jump in ID; valid only when no stall.
- `pcWrite`  out  1: PC enable (0 = hold).
- `stallIFID`  out  1: IF/ID hold.
- `flushIFID`  out  1: IF/ID squash.
- `flushIDEX`  out  1: ID/EX bubble insert.
- `stallCnt`, `flushCnt`  out  `CNT_W` each: saturating event counters.

## Operation
- Scoreboard slots `exSlot` and `memSlot`, each {valid, reg[4:0], isLoad}.
- Every clock:
  - `memSlot <= exSlot`.
  - `exSlot <=` {1, wrRegID, memReadID} if `validID && regWriteID && wrRegID != 0 && !stall`; otherwise invalid. A stall inserts a bubble, matching ID/EX being flushed.
- A slot `s` matches when `s.valid` and (`useRsID && rsID == s.reg`) or (`useRtID && rtID == s.reg`). Register 0 never matches because $0 never enters a slot.
- `loadUse` = `validID && exSlot.isLoad && match(exSlot)`.
- `brHaz` = `validID && branchID && (match(exSlot) || (memSlot.isLoad && match(memSlot)))`. A branch behind an ALU op waits 1 cycle; a branch behind a load waits 2 cycles.
- `stall` = `loadUse || brHaz`.
- Output equations:
  - `pcWrite = !stall`
  - `stallIFID = stall`
  - `flushIDEX = stall`
  - `flushIFID = validID && takenID && !stall`
- Priority: when stall and taken are both asserted, stall wins and `flushIFID` stays 0. The branch re-evaluates once the hazard clears.
- `stallCnt` increments on every cycle with `stall` = 1. `flushCnt` increments on every cycle with `flushIFID` = 1. Both saturate at all-ones and do not wrap.

## Timing
- Outputs are combinational from the registered slots and the current ID inputs (Mealy). A stall takes effect in the same cycle the hazard appears in ID.
- Latency:
  - Load-use: exactly 1 stall cycle.
  - Branch after ALU producer: 1 cycle.
  - Branch immediately after load: 2 cycles.
  - Branch two instructions after load: 1 cycle.
- Reset, asserted asynchronously:
  - Both slots become invalid and both counters go to 0.
  - As a result `pcWrite` = 1 and `stallIFID` = `flushIDEX` = 0 immediately. `flushIFID` follows its inputs.
  - Reset asserted during a stall releases the stall at once. No partial slot state survives.
- `validID` = 0: no outputs are asserted and no slot is loaded.
- Counters at saturation remain at all-ones under further events.

## Structure
- Shared package `pipe_pkg`:
  - the slot record typedef {valid, reg, isLoad}
  - `REG_ZERO` = 5'd0
  - register-number width `REG_W` = 5
- Optional sub-module `sat_counter` (parameter width, inc, clk, reset), instantiated twice for the counters.
- Everything else stays in one module.

## Test plan
- Load-use: `lw $2` then `add $3,$2,$4` (useRs, rs=2) → exactly one cycle of `pcWrite`=0, `stallIFID`=1, `flushIDEX`=1; `stallCnt` reaches 1.
- Branch after load: `lw $2` then `beq $2,$0` with takenID=1 → two stall cycles with `flushIFID`=0, then one cycle of `flushIFID`=1; `stallCnt`=2, `flushCnt`=1.
- Branch after ALU producer: `add $5` then `bne $5,$6` → one stall cycle. The same sequence with one independent instruction between them → no stall.
- $0 and unused operand: `lw $0` then use of $0 → no stall. `lw $7` then an instruction with rt=7 but useRtID=0 → no stall.
- Reset mid-stall: assert `reset` during the second stall cycle of the branch-after-load case → `pcWrite`=1 within the same cycle, both counters 0. After release, a fresh `add` in ID does not stall.
- Saturation: force CNT_W=4 and run 20 load-use pairs → `stallCnt` holds at 15.
